// File: rtl/rv32_pkg.sv
// Shared writeback-stage types: result-select codes, load funct3 codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

  // Result source for non-load instructions; code 2'b11 is treated as ALU.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_PC4 = 2'b01,
    WB_IMM = 2'b10
  } wb_sel_e;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte/half of an aligned load word.
// Latency: purely combinational.
// Backpressure: none.
module load_formatter
  import rv32_pkg::*;
#(
  parameter int Data_Width = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [Data_Width-1:0] word,
  output logic [Data_Width-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the byte and half addressed by the low address bits.
  always_comb begin
    sel_byte = word[7:0];
    case (offset)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
    sel_half = offset[1] ? word[31:16] : word[15:0];
  end

  // Sign- or zero-extend by load type; unknown codes pass the whole word.
  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(Data_Width-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {{(Data_Width-8){1'b0}}, sel_byte};
      F3_LH:   data = {{(Data_Width-16){sel_half[15]}}, sel_half};
      F3_LHU:  data = {{(Data_Width-16){1'b0}}, sel_half};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects/format results and drives one registered RF write per commit.
// Latency: 1 cycle for non-loads; loads commit the cycle after dmem_rvalid.
// Backpressure: in_ready drops while a load is outstanding; a stalled load times out.
module writeback_stage
  import rv32_pkg::*;
#(
  parameter int Data_Width   = 32,
  parameter int AddrRegWidth = 5,
  parameter int Load_Timeout = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    reg_write,
  input  logic                    mem_read,
  input  logic [1:0]              wb_sel,
  input  logic [2:0]              funct3,
  input  logic [AddrRegWidth-1:0] rd,
  input  logic [Data_Width-1:0]   alu_result,
  input  logic [Data_Width-1:0]   pc_plus4,
  input  logic [Data_Width-1:0]   imm,
  input  logic                    dmem_rvalid,
  input  logic [Data_Width-1:0]   dmem_rdata,
  output logic                    rf_en,
  output logic [AddrRegWidth-1:0] rf_rd,
  output logic [Data_Width-1:0]   rf_data,
  output logic                    pend_valid,
  output logic [AddrRegWidth-1:0] pend_rd,
  output logic                    load_fault,
  output logic [31:0]             retire_count
);

  // Last WAIT_LOAD cycle index (counter value) before the load is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(Load_Timeout - 1);

  wb_state_e               state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [AddrRegWidth-1:0] ld_rd_q;
  logic [2:0]              ld_f3_q;
  logic [1:0]              ld_off_q;
  logic                    ld_we_q;

  logic                    latch_load;
  logic                    commit;
  logic                    write_d;
  logic                    fault_d;
  logic [AddrRegWidth-1:0] rd_d;
  logic [Data_Width-1:0]   data_d;
  logic [Data_Width-1:0]   sel_data;
  logic [Data_Width-1:0]   fmt_data;

  load_formatter #(
    .Data_Width(Data_Width)
  ) u_fmt (
    .funct3 (ld_f3_q),
    .offset (ld_off_q),
    .word   (dmem_rdata),
    .data   (fmt_data)
  );

  assign in_ready   = (state_q == IDLE);
  assign pend_valid = (state_q == WAIT_LOAD);
  assign pend_rd    = ld_rd_q;

  // Result mux for non-load instructions.
  always_comb begin
    sel_data = alu_result;
    case (wb_sel)
      WB_PC4:  sel_data = pc_plus4;
      WB_IMM:  sel_data = imm;
      default: sel_data = alu_result;
    endcase
  end

  // Next-state and commit decisions; rf index/data only move when a write happens.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_load = 1'b0;
    commit     = 1'b0;
    write_d    = 1'b0;
    fault_d    = 1'b0;
    rd_d       = rf_rd;
    data_d     = rf_data;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_read) begin
            state_d    = WAIT_LOAD;
            cnt_d      = '0;
            latch_load = 1'b1;
          end else begin
            commit  = 1'b1;
            write_d = reg_write && (rd != '0);
            if (write_d) begin
              rd_d   = rd;
              data_d = sel_data;
            end
          end
        end
      end
      WAIT_LOAD: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the final allowed cycle still wins over the timeout.
        if (dmem_rvalid) begin
          state_d = IDLE;
          commit  = 1'b1;
          write_d = ld_we_q && (ld_rd_q != '0);
          if (write_d) begin
            rd_d   = ld_rd_q;
            data_d = fmt_data;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Registered write port, fault pulse, load context and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      ld_rd_q      <= '0;
      ld_f3_q      <= '0;
      ld_off_q     <= '0;
      ld_we_q      <= 1'b0;
      rf_en        <= 1'b0;
      rf_rd        <= '0;
      rf_data      <= '0;
      load_fault   <= 1'b0;
      retire_count <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rf_en      <= write_d;
      rf_rd      <= rd_d;
      rf_data    <= data_d;
      load_fault <= fault_d;
      if (latch_load) begin
        ld_rd_q  <= rd;
        ld_f3_q  <= funct3;
        ld_off_q <= alu_result[1:0];
        ld_we_q  <= reg_write;
      end
      if (commit) retire_count <= retire_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        reg_write;
  logic        mem_read;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_fault;
  logic [31:0] retire_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_retire = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .wb_sel       (wb_sel),
    .funct3       (funct3),
    .rd           (rd),
    .alu_result   (alu_result),
    .pc_plus4     (pc_plus4),
    .imm          (imm),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .rf_en        (rf_en),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .pend_valid   (pend_valid),
    .pend_rd      (pend_rd),
    .load_fault   (load_fault),
    .retire_count (retire_count)
  );

  // Advance one clock; outputs are then observed 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting cycle.
  task automatic issue(input logic [4:0] r, input logic [1:0] sel, input logic [31:0] alu,
                       input logic we, input logic mr, input logic [2:0] f3);
    in_valid   = 1'b1;
    rd         = r;
    wb_sel     = sel;
    alu_result = alu;
    reg_write  = we;
    mem_read   = mr;
    funct3     = f3;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (in_ready !== 1'b1 || rf_en !== 1'b0 || pend_valid !== 1'b0 || load_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready=%b en=%b pend=%b fault=%b, want 1 0 0 0",
               in_ready, rf_en, pend_valid, load_fault);
    end
    vectors++;
    if (rf_rd !== 5'd0 || rf_data !== 32'd0 || pend_rd !== 5'd0 || retire_count !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_data: got rd=%0d data=%h prd=%0d cnt=%0d, want all 0",
               rf_rd, rf_data, pend_rd, retire_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alu();
    issue(5'd5, 2'b00, 32'h0000_00AA, 1'b1, 1'b0, 3'b000);
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h0000_00AA || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL alu_write: got en=%b rd=%0d data=%h cnt=%0d, want 1 5 000000aa %0d",
               rf_en, rf_rd, rf_data, retire_count, exp_retire);
    end
    step();
    vectors++;
    if (rf_en !== 1'b0 || rf_rd !== 5'd5 || rf_data !== 32'h0000_00AA) begin
      miscompares++;
      $display("FAIL alu_pulse_hold: got en=%b rd=%0d data=%h, want 0 5 000000aa", rf_en, rf_rd, rf_data);
    end
  endtask

  task automatic test_wb_sel();
    logic [1:0]  sel_t [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [4:0]  rd_t  [4] = '{5'd6, 5'd8, 5'd9, 5'd10};
    logic        we_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        en_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0]  erd_t [4] = '{5'd6, 5'd8, 5'd9, 5'd9};
    logic [31:0] dat_t [4] = '{32'h0000_0104, 32'h1234_5000, 32'h0000_DEAD, 32'h0000_DEAD};
    pc_plus4 = 32'h0000_0104;
    imm      = 32'h1234_5000;
    for (int i = 0; i < 4; i++) begin
      issue(rd_t[i], sel_t[i], 32'h0000_DEAD, we_t[i], 1'b0, 3'b000);
      exp_retire++;
      vectors++;
      if (rf_en !== en_t[i] || rf_rd !== erd_t[i] || rf_data !== dat_t[i] || retire_count !== exp_retire) begin
        miscompares++;
        $display("FAIL wb_sel_%0d: got en=%b rd=%0d data=%h cnt=%0d, want %b %0d %h %0d", i,
                 rf_en, rf_rd, rf_data, retire_count, en_t[i], erd_t[i], dat_t[i], exp_retire);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    in_valid   = 1'b1;
    reg_write  = 1'b1;
    mem_read   = 1'b0;
    wb_sel     = 2'b00;
    rd         = 5'd3;
    alu_result = 32'h1111_1111;
    step();
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd3 || rf_data !== 32'h1111_1111 || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL b2b_first: got en=%b rd=%0d data=%h cnt=%0d, want 1 3 11111111 %0d",
               rf_en, rf_rd, rf_data, retire_count, exp_retire);
    end
    rd         = 5'd4;
    alu_result = 32'h2222_2222;
    step();
    in_valid = 1'b0;
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h2222_2222 || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL b2b_second: got en=%b rd=%0d data=%h cnt=%0d, want 1 4 22222222 %0d",
               rf_en, rf_rd, rf_data, retire_count, exp_retire);
    end
    step();
  endtask

  task automatic test_load_format();
    logic [2:0]  f3_t  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b011};
    logic [1:0]  off_t [7] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [31:0] exp_t [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234,
                               32'h80FF_1234, 32'h0000_0012, 32'h80FF_1234};
    for (int i = 0; i < 7; i++) begin
      issue(5'd11, 2'b00, {30'h100, off_t[i]}, 1'b1, 1'b1, f3_t[i]);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h80FF_1234;
      step();
      dmem_rvalid = 1'b0;
      exp_retire++;
      vectors++;
      if (rf_en !== 1'b1 || rf_rd !== 5'd11 || rf_data !== exp_t[i] || retire_count !== exp_retire) begin
        miscompares++;
        $display("FAIL load_fmt_%0d: got en=%b rd=%0d data=%h cnt=%0d, want 1 11 %h %0d", i,
                 rf_en, rf_rd, rf_data, retire_count, exp_t[i], exp_retire);
      end
      step();
    end
  endtask

  task automatic test_load_wait();
    issue(5'd7, 2'b00, 32'h0000_0200, 1'b1, 1'b1, 3'b010);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (in_ready !== 1'b0 || pend_valid !== 1'b1 || pend_rd !== 5'd7 || rf_en !== 1'b0) begin
        miscompares++;
        $display("FAIL load_wait_c%0d: got ready=%b pend=%b prd=%0d en=%b, want 0 1 7 0",
                 k, in_ready, pend_valid, pend_rd, rf_en);
      end
      if (k == 3) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hCAFE_F00D || in_ready !== 1'b1 ||
        pend_valid !== 1'b0 || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL load_wait_commit: got en=%b rd=%0d data=%h ready=%b pend=%b cnt=%0d, want 1 7 cafef00d 1 0 %0d",
               rf_en, rf_rd, rf_data, in_ready, pend_valid, retire_count, exp_retire);
    end
    step();
    vectors++;
    if (rf_en !== 1'b0) begin
      miscompares++;
      $display("FAIL load_wait_pulse: got en=%b, want 0", rf_en);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    issue(5'd12, 2'b00, 32'h0000_0300, 1'b1, 1'b1, 3'b010);
    for (int k = 0; k < 255; k++) begin
      if (pend_valid !== 1'b1 || load_fault !== 1'b0 || in_ready !== 1'b0) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL timeout_wait: got %0d bad WAIT_LOAD cycles, want 0", bad);
    end
    vectors++;
    if (load_fault !== 1'b1 || rf_en !== 1'b0 || in_ready !== 1'b1 || pend_valid !== 1'b0 ||
        retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL timeout_fault: got fault=%b en=%b ready=%b pend=%b cnt=%0d, want 1 0 1 0 %0d",
               load_fault, rf_en, in_ready, pend_valid, retire_count, exp_retire);
    end
    step();
    vectors++;
    if (load_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: got fault=%b, want 0", load_fault);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    step();
    dmem_rvalid = 1'b0;
    step();
    vectors++;
    if (rf_en !== 1'b0 || rf_data === 32'h5555_AAAA || retire_count !== exp_retire || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stray_rvalid: got en=%b data=%h cnt=%0d ready=%b, want 0 not-5555aaaa %0d 1",
               rf_en, rf_data, retire_count, in_ready, exp_retire);
    end
  endtask

  task automatic test_timeout_race();
    issue(5'd13, 2'b00, 32'h0000_0400, 1'b1, 1'b1, 3'b010);
    for (int k = 0; k < 254; k++) step();
    vectors++;
    if (pend_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL race_still_wait: got pend=%b, want 1", pend_valid);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0BAD_BEEF;
    step();
    dmem_rvalid = 1'b0;
    exp_retire++;
    vectors++;
    if (load_fault !== 1'b0 || rf_en !== 1'b1 || rf_rd !== 5'd13 || rf_data !== 32'h0BAD_BEEF ||
        retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL race_data_wins: got fault=%b en=%b rd=%0d data=%h cnt=%0d, want 0 1 13 0badbeef %0d",
               load_fault, rf_en, rf_rd, rf_data, retire_count, exp_retire);
    end
    step();
  endtask

  task automatic test_rd_zero();
    pc_plus4 = 32'h0000_0808;
    issue(5'd0, 2'b01, 32'h0000_0000, 1'b1, 1'b0, 3'b000);
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b0 || rf_rd !== 5'd13 || rf_data !== 32'h0BAD_BEEF || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL rd0_jal: got en=%b rd=%0d data=%h cnt=%0d, want 0 13 0badbeef %0d",
               rf_en, rf_rd, rf_data, retire_count, exp_retire);
    end
    issue(5'd0, 2'b00, 32'h0000_0500, 1'b1, 1'b1, 3'b010);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    step();
    dmem_rvalid = 1'b0;
    exp_retire++;
    vectors++;
    if (rf_en !== 1'b0 || rf_data !== 32'h0BAD_BEEF || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL rd0_load: got en=%b data=%h cnt=%0d, want 0 0badbeef %0d",
               rf_en, rf_data, retire_count, exp_retire);
    end
    step();
  endtask

  task automatic test_reset_mid_load();
    issue(5'd14, 2'b00, 32'h0000_0600, 1'b1, 1'b1, 3'b000);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h9999_9999;
    step();
    dmem_rvalid = 1'b0;
    step();
    exp_retire = 0;
    vectors++;
    if (rf_en !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'd0 || pend_valid !== 1'b0 ||
        pend_rd !== 5'd0 || load_fault !== 1'b0 || in_ready !== 1'b1 || retire_count !== exp_retire) begin
      miscompares++;
      $display("FAIL reset_mid_load: got en=%b rd=%0d data=%h pend=%b prd=%0d fault=%b ready=%b cnt=%0d, want reset values",
               rf_en, rf_rd, rf_data, pend_valid, pend_rd, load_fault, in_ready, retire_count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    wb_sel      = 2'b00;
    funct3      = 3'b000;
    rd          = 5'd0;
    alu_result  = 32'd0;
    pc_plus4    = 32'd0;
    imm         = 32'd0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    #1;
    test_reset();
    test_alu();
    test_wb_sel();
    test_back_to_back();
    test_load_format();
    test_load_wait();
    test_timeout();
    test_timeout_race();
    test_rd_zero();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
